dram_traffic_gen: RTL and testbench

Synthesizable initiator for the dram_controller user port: clk_i, rst_i, read, write, address, write_data, read_data, ack, busy. On start it writes NUM words of LFSR-derived data to consecutive burst addresses, then reads them back and compares. It reports pass/fail, an error count and the first failing address. It replaces bench-driven stimulus for on-board bring-up and long soak runs.

---
 rtl/dram_traffic_gen.sv | 270 +++++++++++++++++++++++++++
 tb/tb_dram_traffic_gen.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_traffic_gen.sv
// Self-checking DRAM traffic initiator: writes an LFSR-derived pattern to a run of
// burst addresses, reads it back and reports pass/fail, error count and first bad address.
`timescale 1ns/1ps
module dram_traffic_gen #(
    parameter int          ADDR_W    = 26,
    parameter int          DATA_W    = 128,
    parameter int          ADDR_STEP = 8,
    parameter logic [31:0] SEED      = 32'hACE1_2468,
    parameter int          TIMEOUT   = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_words,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    input  logic              ack,
    input  logic              busy,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int                LANES     = DATA_W / 32;
    localparam int                WAIT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [31:0]       POLY      = 32'h8020_0003;
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        lfsr_next = {1'b0, v[31:1]} ^ (v[0] ? POLY : 32'h0000_0000);
    endfunction

    // Lane i carries the word's LFSR value rotated left by i.
    function automatic logic [DATA_W-1:0] pattern(input logic [31:0] v);
        logic [63:0]       dbl;
        logic [DATA_W-1:0] p;
        dbl = {v, v};
        p   = {DATA_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            p[32*i +: 32] = dbl[63-i -: 32];
        end
        pattern = p;
    endfunction

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   base_r, base_s;
    logic [15:0]         num_r, num_s;
    logic [15:0]         k_r, k_s;
    logic [15:0]         last_k_s;
    logic [31:0]         lfsr_r, lfsr_s;
    logic [ADDR_W-1:0]   cur_r, cur_s;
    logic [WAIT_W-1:0]   wait_r, wait_s;
    logic                read_r, read_s;
    logic                write_r, write_s;
    logic [ADDR_W-1:0]   address_r, address_s;
    logic [DATA_W-1:0]   wdata_r, wdata_s;
    logic                running_r, running_s;
    logic                done_r, done_s;
    logic                pass_r, pass_s;
    logic                timeout_r, timeout_s;
    logic [15:0]         err_r, err_s;
    logic [ADDR_W-1:0]   ferr_r, ferr_s;
    logic [DATA_W-1:0]   pat_s;

    assign pat_s    = pattern(lfsr_r);
    assign last_k_s = num_r - 16'd1;

    // Next-state and next-output computation for the test sequencer.
    always_comb begin
        state_s   = state_r;
        base_s    = base_r;
        num_s     = num_r;
        k_s       = k_r;
        lfsr_s    = lfsr_r;
        cur_s     = cur_r;
        wait_s    = wait_r;
        read_s    = read_r;
        write_s   = write_r;
        address_s = address_r;
        wdata_s   = wdata_r;
        running_s = running_r;
        done_s    = 1'b0;
        pass_s    = pass_r;
        timeout_s = timeout_r;
        err_s     = err_r;
        ferr_s    = ferr_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    base_s    = base_addr;
                    num_s     = num_words;
                    k_s       = 16'd0;
                    lfsr_s    = SEED;
                    cur_s     = base_addr;
                    err_s     = 16'd0;
                    ferr_s    = {ADDR_W{1'b0}};
                    timeout_s = 1'b0;
                    running_s = 1'b1;
                    if (num_words == 16'd0) begin
                        state_s = ST_FINISH;
                    end else begin
                        state_s = ST_WR_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if (!busy) begin
                    write_s   = 1'b1;
                    address_s = cur_r;
                    wdata_s   = pat_s;
                    wait_s    = {WAIT_W{1'b0}};
                    state_s   = ST_WR_WAIT;
                end else begin
                    state_s = ST_WR_REQ;
                end
            end
            ST_WR_WAIT: begin
                if (ack) begin
                    write_s = 1'b0;
                    if (k_r == last_k_s) begin
                        k_s     = 16'd0;
                        lfsr_s  = SEED;
                        cur_s   = base_r;
                        state_s = ST_RD_REQ;
                    end else begin
                        k_s     = k_r + 16'd1;
                        lfsr_s  = lfsr_next(lfsr_r);
                        cur_s   = cur_r + STEP;
                        state_s = ST_WR_REQ;
                    end
                end else if (wait_r == WAIT_LAST) begin
                    write_s   = 1'b0;
                    timeout_s = 1'b1;
                    state_s   = ST_FINISH;
                end else begin
                    wait_s = wait_r + WAIT_ONE;
                end
            end
            ST_RD_REQ: begin
                if (!busy) begin
                    read_s    = 1'b1;
                    address_s = cur_r;
                    wait_s    = {WAIT_W{1'b0}};
                    state_s   = ST_RD_WAIT;
                end else begin
                    state_s = ST_RD_REQ;
                end
            end
            ST_RD_WAIT: begin
                if (ack) begin
                    read_s = 1'b0;
                    // Count saturates; the first mismatch is the one seen while the count is still zero.
                    if (read_data != pat_s) begin
                        if (err_r != 16'hFFFF) begin
                            err_s = err_r + 16'd1;
                        end else begin
                            err_s = err_r;
                        end
                        if (err_r == 16'd0) begin
                            ferr_s = address_r;
                        end else begin
                            ferr_s = ferr_r;
                        end
                    end else begin
                        err_s = err_r;
                    end
                    if (k_r == last_k_s) begin
                        state_s = ST_FINISH;
                    end else begin
                        k_s     = k_r + 16'd1;
                        lfsr_s  = lfsr_next(lfsr_r);
                        cur_s   = cur_r + STEP;
                        state_s = ST_RD_REQ;
                    end
                end else if (wait_r == WAIT_LAST) begin
                    read_s    = 1'b0;
                    timeout_s = 1'b1;
                    state_s   = ST_FINISH;
                end else begin
                    wait_s = wait_r + WAIT_ONE;
                end
            end
            ST_FINISH: begin
                done_s    = 1'b1;
                running_s = 1'b0;
                pass_s    = (err_r == 16'd0) && !timeout_r;
                state_s   = ST_IDLE;
            end
            default: begin
                read_s    = 1'b0;
                write_s   = 1'b0;
                running_s = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            base_r    <= {ADDR_W{1'b0}};
            num_r     <= 16'd0;
            k_r       <= 16'd0;
            lfsr_r    <= SEED;
            cur_r     <= {ADDR_W{1'b0}};
            wait_r    <= {WAIT_W{1'b0}};
            read_r    <= 1'b0;
            write_r   <= 1'b0;
            address_r <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            running_r <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            timeout_r <= 1'b0;
            err_r     <= 16'd0;
            ferr_r    <= {ADDR_W{1'b0}};
        end else begin
            state_r   <= state_s;
            base_r    <= base_s;
            num_r     <= num_s;
            k_r       <= k_s;
            lfsr_r    <= lfsr_s;
            cur_r     <= cur_s;
            wait_r    <= wait_s;
            read_r    <= read_s;
            write_r   <= write_s;
            address_r <= address_s;
            wdata_r   <= wdata_s;
            running_r <= running_s;
            done_r    <= done_s;
            pass_r    <= pass_s;
            timeout_r <= timeout_s;
            err_r     <= err_s;
            ferr_r    <= ferr_s;
        end
    end

    assign read           = read_r;
    assign write          = write_r;
    assign address        = address_r;
    assign write_data     = wdata_r;
    assign running        = running_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign timeout        = timeout_r;
    assign err_count      = err_r;
    assign first_err_addr = ferr_r;

endmodule

// File: tb/tb_dram_traffic_gen.sv
// Bench for dram_traffic_gen: memory responder with configurable latency, busy, spurious ack
// and read corruption, checked against a word-level model of addresses and data patterns.
`timescale 1ns/1ps
module tb_dram_traffic_gen;

    localparam int          ADDR_W    = 26;
    localparam int          DATA_W    = 128;
    localparam int          ADDR_STEP = 8;
    localparam int          TIMEOUT   = 64;
    localparam logic [31:0] SEED      = 32'hACE1_2468;
    localparam logic [31:0] POLY      = 32'h8020_0003;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       num_words;
    logic              read, write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              ack, busy;
    logic              running, done, pass, timeout;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;

    dram_traffic_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_STEP(ADDR_STEP), .SEED(SEED), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start(start), .base_addr(base_addr), .num_words(num_words),
        .read(read), .write(write), .address(address), .write_data(write_data),
        .read_data(read_data), .ack(ack), .busy(busy), .running(running), .done(done),
        .pass(pass), .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // responder configuration and logs
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    bit                never_ack = 1'b0, rand_busy = 1'b0, spur_ack = 1'b0, rand_corrupt = 1'b0;
    int                corrupt_idx = -1;
    int                ack_dly = 3;
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    logic [ADDR_W-1:0] rd_addr_q[$];
    int                bad_rd_q[$];
    int                wr_high = 0, rd_high = 0, rd_starts = 0;

    // word k of the sequence: LFSR advanced k times from the seed
    function automatic logic [31:0] model_lfsr(input int k);
        logic [31:0] x;
        x = SEED;
        repeat (k) x = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
        return x;
    endfunction

    function automatic logic [DATA_W-1:0] model_data(input int k);
        logic [31:0]       x, r;
        logic [DATA_W-1:0] d;
        x = model_lfsr(k);
        d = '0;
        for (int i = 0; i < DATA_W / 32; i++) begin
            r = (i == 0) ? x : ((x << i) | (x >> (32 - i)));
            d[32*i +: 32] = r;
        end
        return d;
    endfunction

    function automatic logic [ADDR_W-1:0] model_addr(input logic [ADDR_W-1:0] b, input int k);
        logic [31:0] s;
        s = 32'(b) + 32'(k * ADDR_STEP);
        return s[ADDR_W-1:0];
    endfunction

    // Responder: acts on the falling edge so the DUT sees stable inputs at the rising edge.
    initial begin : responder
        bit                pend, pend_wr, ack_last, bad;
        int                cnt;
        logic [ADDR_W-1:0] cap_addr;
        logic [DATA_W-1:0] cap_data, rd;
        pend = 0; pend_wr = 0; ack_last = 0; cnt = 0; cap_addr = '0; cap_data = '0;
        ack = 1'b0; busy = 1'b0; read_data = '0;
        forever begin
            @(negedge clk_i);
            if (ack_last) begin
                checks++;
                if (read || write) begin
                    errors++;
                    $display("FAIL req_after_ack: read=%0b write=%0b, expected both 0", read, write);
                end
            end
            ack_last = 0;
            ack = 1'b0;
            if (write) wr_high++;
            if (read) rd_high++;
            if (rst_i) begin
                pend = 0;
            end else if (pend) begin
                if (!(write || read)) begin
                    pend = 0;
                end else begin
                    checks++;
                    if (address !== cap_addr || (pend_wr && (!write || write_data !== cap_data)) ||
                        (!pend_wr && !read)) begin
                        errors++;
                        $display("FAIL req_hold: addr %h wr %0b rd %0b, expected addr %h held", address, write, read, cap_addr);
                    end
                    cnt++;
                    if (!never_ack && cnt >= ack_dly) begin
                        ack = 1'b1; ack_last = 1; pend = 0;
                        if (pend_wr) begin
                            mem[cap_addr] = cap_data;
                            wr_addr_q.push_back(cap_addr);
                            wr_data_q.push_back(cap_data);
                        end else begin
                            rd = mem.exists(cap_addr) ? mem[cap_addr] : '0;
                            bad = (rd_addr_q.size() == corrupt_idx) || (rand_corrupt && $urandom_range(0, 3) == 0);
                            if (bad) begin
                                rd[0] = ~rd[0];
                                bad_rd_q.push_back(rd_addr_q.size());
                            end
                            read_data = rd;
                            rd_addr_q.push_back(cap_addr);
                        end
                    end
                end
            end else if (write || read) begin
                checks++;
                if (write && read) begin
                    errors++;
                    $display("FAIL both_req: read=1 write=1, expected only one");
                end
                pend = 1; pend_wr = write; cnt = 0; cap_addr = address; cap_data = write_data;
                if (read) rd_starts++;
            end else if (spur_ack && $urandom_range(0, 3) == 0) begin
                ack = 1'b1;
            end
            busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); bad_rd_q.delete();
        wr_high = 0; rd_high = 0; rd_starts = 0;
        corrupt_idx = -1; never_ack = 0; rand_busy = 0; spur_ack = 0; rand_corrupt = 0; ack_dly = 3;
    endtask

    // Leaves the caller on the falling edge just after start was sampled.
    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [15:0] n);
        @(negedge clk_i);
        base_addr = b; num_words = n; start = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int c = 0; c < 20000; c++) begin
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({read, write, running, done, pass, timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 000000", {read, write, running, done, pass, timeout});
        end
        checks++;
        if (address !== '0 || write_data !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr %h data %h, expected 0", address, write_data);
        end
        checks++;
        if (err_count !== 16'd0 || first_err_addr !== '0) begin
            errors++;
            $display("FAIL reset_status: err %h first %h, expected 0", err_count, first_err_addr);
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({read, write, running, done} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b, expected 0000", {read, write, running, done});
        end
    endtask

    task automatic test_ideal();
        bit seen;
        clear_logs();
        pulse_start('0, 16'd4);
        checks++;
        if (write !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL ideal_cycle1: write %b running %b, expected 0 1", write, running);
        end
        @(negedge clk_i);
        checks++;
        if (write !== 1'b1 || address !== '0) begin
            errors++;
            $display("FAIL ideal_latency: write %b addr %h, expected 1 0", write, address);
        end
        // a start while running must be ignored
        start = 1'b1; base_addr = 26'h55; num_words = 16'd0;
        @(negedge clk_i);
        start = 1'b0;
        wait_done(seen);
        checks++;
        if (!seen || pass !== 1'b1 || err_count !== 16'd0 || timeout !== 1'b0 || first_err_addr !== '0) begin
            errors++;
            $display("FAIL ideal_status: done %0b pass %b err %0d to %b first %h, expected 1 1 0 0 0",
                     seen, pass, err_count, timeout, first_err_addr);
        end
        checks++;
        if (wr_addr_q.size() != 4 || rd_addr_q.size() != 4) begin
            errors++;
            $display("FAIL ideal_count: writes %0d reads %0d, expected 4 4", wr_addr_q.size(), rd_addr_q.size());
        end
        for (int k = 0; k < 4 && k < wr_addr_q.size() && k < rd_addr_q.size(); k++) begin
            checks++;
            if (wr_addr_q[k] !== model_addr('0, k) || wr_data_q[k] !== model_data(k) || rd_addr_q[k] !== model_addr('0, k)) begin
                errors++;
                $display("FAIL ideal_word%0d: wr %h/%h rd %h, expected %h/%h", k, wr_addr_q[k], wr_data_q[k],
                         rd_addr_q[k], model_addr('0, k), model_data(k));
            end
        end
        @(negedge clk_i);
        checks++;
        if (done !== 1'b0 || running !== 1'b0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL ideal_pulse: done %b running %b pass %b, expected 0 0 1", done, running, pass);
        end
    endtask

    task automatic test_corrupt();
        bit seen;
        clear_logs();
        corrupt_idx = 2;
        pulse_start(26'h100, 16'd4);
        wait_done(seen);
        checks++;
        if (!seen || err_count !== 16'd1 || first_err_addr !== 26'h110 || pass !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL corrupt: done %0b err %0d first %h pass %b to %b, expected 1 1 110 0 0",
                     seen, err_count, first_err_addr, pass, timeout);
        end
    endtask

    task automatic test_zero();
        clear_logs();
        pulse_start(26'h200, 16'd0);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_early: done %b, expected 0", done);
        end
        @(negedge clk_i);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: done %b pass %b, expected 1 1", done, pass);
        end
        repeat (4) @(negedge clk_i);
        checks++;
        if (wr_high != 0 || rd_high != 0 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_noreq: write cycles %0d read cycles %0d done %b, expected 0 0 0", wr_high, rd_high, done);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        clear_logs();
        never_ack = 1;
        pulse_start(26'h40, 16'd3);
        wait_done(seen);
        checks++;
        if (!seen || wr_high != TIMEOUT || rd_high != 0) begin
            errors++;
            $display("FAIL timeout_hold: done %0b write cycles %0d read cycles %0d, expected 1 %0d 0",
                     seen, wr_high, rd_high, TIMEOUT);
        end
        checks++;
        if (timeout !== 1'b1 || pass !== 1'b0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL timeout_status: to %b pass %b err %0d, expected 1 0 0", timeout, pass, err_count);
        end
        repeat (5) @(negedge clk_i);
        checks++;
        if (timeout !== 1'b1 || write !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL timeout_held: to %b write %b running %b, expected 1 0 0", timeout, write, running);
        end
        never_ack = 0;
    endtask

    task automatic test_wrap();
        bit seen;
        clear_logs();
        pulse_start(26'h3FFFFF8, 16'd2);
        wait_done(seen);
        checks++;
        if (!seen || pass !== 1'b1 || timeout !== 1'b0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL wrap_status: done %0b pass %b to %b err %0d, expected 1 1 0 0", seen, pass, timeout, err_count);
        end
        checks++;
        if (wr_addr_q.size() != 2 || rd_addr_q.size() != 2) begin
            errors++;
            $display("FAIL wrap_count: writes %0d reads %0d, expected 2 2", wr_addr_q.size(), rd_addr_q.size());
        end else if (wr_addr_q[0] !== 26'h3FFFFF8 || wr_addr_q[1] !== 26'h0 || rd_addr_q[1] !== 26'h0) begin
            errors++;
            $display("FAIL wrap_addr: %h %h rd %h, expected 3fffff8 0000000 0000000", wr_addr_q[0], wr_addr_q[1], rd_addr_q[1]);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        clear_logs();
        pulse_start('0, 16'd4);
        for (int c = 0; c < 2000 && rd_starts < 2; c++) @(negedge clk_i);
        checks++;
        if (rd_starts < 2 || read !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_reach: read starts %0d read %b, expected 2 1", rd_starts, read);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({read, write, running, done, pass, timeout} !== 6'b0 || err_count !== 16'd0 ||
            first_err_addr !== '0 || address !== '0 || write_data !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: flags %b err %0d first %h addr %h, expected all 0",
                     {read, write, running, done, pass, timeout}, err_count, first_err_addr, address);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        clear_logs();
        pulse_start('0, 16'd1);
        wait_done(seen);
        checks++;
        if (!seen || pass !== 1'b1 || wr_addr_q.size() != 1 || rd_addr_q.size() != 1) begin
            errors++;
            $display("FAIL rstmid_rerun: done %0b pass %b writes %0d reads %0d, expected 1 1 1 1",
                     seen, pass, wr_addr_q.size(), rd_addr_q.size());
        end
    endtask

    task automatic test_random();
        bit                seen;
        logic [ADDR_W-1:0] b, exp_first;
        int                n;
        for (int it = 0; it < 4; it++) begin
            clear_logs();
            rand_busy = 1; spur_ack = 1; rand_corrupt = 1;
            ack_dly = $urandom_range(1, 5);
            b = ADDR_W'($urandom);
            b[2:0] = 3'b000;
            n = $urandom_range(1, 10);
            pulse_start(b, 16'(n));
            wait_done(seen);
            exp_first = (bad_rd_q.size() > 0) ? model_addr(b, bad_rd_q[0]) : '0;
            checks++;
            if (!seen || err_count !== 16'(bad_rd_q.size()) || first_err_addr !== exp_first ||
                pass !== (bad_rd_q.size() == 0) || timeout !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_status: done %0b err %0d first %h pass %b, expected 1 %0d %h %0b",
                         it, seen, err_count, first_err_addr, pass, bad_rd_q.size(), exp_first, bad_rd_q.size() == 0);
            end
            checks++;
            if (wr_addr_q.size() != n || rd_addr_q.size() != n) begin
                errors++;
                $display("FAIL rand%0d_count: writes %0d reads %0d, expected %0d", it, wr_addr_q.size(), rd_addr_q.size(), n);
            end
            for (int k = 0; k < n && k < wr_addr_q.size() && k < rd_addr_q.size(); k++) begin
                checks++;
                if (wr_addr_q[k] !== model_addr(b, k) || wr_data_q[k] !== model_data(k) || rd_addr_q[k] !== model_addr(b, k)) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d: wr %h/%h rd %h, expected %h/%h", it, k, wr_addr_q[k], wr_data_q[k],
                             rd_addr_q[k], model_addr(b, k), model_data(k));
                end
            end
        end
        clear_logs();
    endtask

    initial begin : main
        rst_i = 1'b1; start = 1'b0; base_addr = '0; num_words = 16'd0;
        test_reset();
        test_ideal();
        test_corrupt();
        test_zero();
        test_timeout();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
